// File: rtl/job_sequencer_pkg.sv
// Shared types and defaults for the job sequencer and its input buffer.
package job_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_WAIT = 2'b10,
    ST_HOLD = 2'b11
  } state_e;

  localparam int DW_DEFAULT    = 8;
  localparam int DEPTH_DEFAULT = 4;

  // Width of a down/up counter that must hold values 0..n-1 (never below 1 bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/job_sequencer_sync_fifo.sv
// Small synchronous FIFO buffering operand jobs ahead of the sequencer.
// Full refuses a push even when a pop happens on the same edge.
module sync_fifo
  import job_sequencer_pkg::*;
#(
  parameter int DW    = DW_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam logic [AW:0] COUNT_FULL = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full      = (count_q == COUNT_FULL);
  assign empty     = (count_q == {(AW+1){1'b0}});
  assign count     = count_q;
  assign rdata     = mem_q[rd_ptr_q];
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // Storage, pointer and occupancy updates for the next edge.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + (AW+1)'(1'b1);
      2'b01:   count_d = count_q - (AW+1)'(1'b1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers; reset empties the buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DW{1'b0}};
      end
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/job_sequencer.sv
// Launches buffered operand jobs one at a time into a start/done compute
// unit, captures each result for a valid/ready consumer and abandons any
// job whose done does not arrive within TIMEOUT cycles.
module job_sequencer
  import job_sequencer_pkg::*;
#(
  parameter int DW           = DW_DEFAULT,
  parameter int DEPTH        = DEPTH_DEFAULT,
  parameter int START_CYCLES = 2,
  parameter int TIMEOUT      = 64,
  localparam int AW          = $clog2(DEPTH),
  localparam int LCW         = cnt_width(START_CYCLES),
  localparam int TCW         = cnt_width(TIMEOUT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          start,
  output logic [DW-1:0] din,
  input  logic          done,
  input  logic [DW-1:0] result,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          busy,
  output logic          timeout_err
);

  localparam logic [LCW-1:0] LOAD_FIRST = LCW'(START_CYCLES - 1);
  localparam logic [TCW-1:0] WAIT_LAST  = TCW'(TIMEOUT - 1);
  localparam logic [AW:0]    COUNT_FULL = (AW+1)'(DEPTH);

  state_e         state_q, state_d;
  logic [LCW-1:0] load_cnt_q, load_cnt_d;
  logic [TCW-1:0] wait_cnt_q, wait_cnt_d;
  logic [DW-1:0]  din_q, din_d;
  logic           out_valid_q, out_valid_d;
  logic [DW-1:0]  out_data_q, out_data_d;
  logic           timeout_err_q, timeout_err_d;

  logic           fifo_push_s;
  logic           fifo_pop_s;
  logic [DW-1:0]  fifo_rdata_s;
  logic           fifo_full_s;
  logic           fifo_empty_s;
  logic [AW:0]    fifo_count_s;

  assign in_ready    = (fifo_count_s != COUNT_FULL);
  assign fifo_push_s = in_valid && !fifo_full_s;

  sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push_s),
    .pop   (fifo_pop_s),
    .wdata (in_data),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // State and datapath registers; reset abandons any job in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      load_cnt_q    <= {LCW{1'b0}};
      wait_cnt_q    <= {TCW{1'b0}};
      din_q         <= {DW{1'b0}};
      out_valid_q   <= 1'b0;
      out_data_q    <= {DW{1'b0}};
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      load_cnt_q    <= load_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      din_q         <= din_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Next-state logic; done outside WAIT is deliberately ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_s) state_d = ST_LOAD;
        else               state_d = ST_IDLE;
      end
      ST_LOAD: begin
        if (load_cnt_q == {LCW{1'b0}}) state_d = ST_WAIT;
        else                           state_d = ST_LOAD;
      end
      ST_WAIT: begin
        if (done)                          state_d = ST_HOLD;
        else if (wait_cnt_q == WAIT_LAST)  state_d = ST_IDLE;
        else                               state_d = ST_WAIT;
      end
      ST_HOLD: begin
        if (out_ready) state_d = ST_IDLE;
        else           state_d = ST_HOLD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pop, counters and captured outputs for each state; done wins over timeout.
  always_comb begin
    fifo_pop_s    = 1'b0;
    din_d         = din_q;
    load_cnt_d    = load_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    timeout_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          fifo_pop_s = 1'b1;
          din_d      = fifo_rdata_s;
          load_cnt_d = LOAD_FIRST;
        end else begin
          fifo_pop_s = 1'b0;
        end
      end
      ST_LOAD: begin
        if (load_cnt_q == {LCW{1'b0}}) begin
          wait_cnt_d = {TCW{1'b0}};
        end else begin
          load_cnt_d = load_cnt_q - LCW'(1'b1);
        end
      end
      ST_WAIT: begin
        if (done) begin
          out_data_d  = result;
          out_valid_d = 1'b1;
        end else if (wait_cnt_q == WAIT_LAST) begin
          timeout_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + TCW'(1'b1);
        end
      end
      ST_HOLD: begin
        if (out_ready) out_valid_d = 1'b0;
        else           out_valid_d = 1'b1;
      end
      default: begin
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Outputs are registers or decodes of the registered state.
  assign start       = (state_q == ST_LOAD);
  assign busy        = (state_q != ST_IDLE);
  assign din         = din_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_job_sequencer.sv
// Scoreboard bench for job_sequencer: a behavioural compute unit answers
// each job with din>>1 after a programmable delay, and a monitor compares
// every delivered result or timeout against the expectation queue.
module tb_job_sequencer;

  localparam int DW = 8;

  typedef struct packed {
    logic          to;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          start;
  logic [DW-1:0] din;
  logic          done;
  logic [DW-1:0] result;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          timeout_err;

  exp_t sb_q[$];
  int   rd_idx;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_to_seen;
  int   cu_delay = 2;
  logic spur_req = 1'b0;

  job_sequencer #(
    .DW(8), .DEPTH(4), .START_CYCLES(2), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .start(start), .din(din), .done(done),
    .result(result), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural compute unit: answers in WAIT after cu_delay cycles, or pulses done on request.
  initial begin
    int wait_n;
    logic in_wait;
    done = 1'b0;
    result = '0;
    wait_n = 0;
    forever begin
      @(negedge clk);
      in_wait = busy && !start && !out_valid && !rst;
      if (spur_req) begin
        done = 1'b1;
        result = 8'hEE;
      end else if (in_wait && wait_n == cu_delay) begin
        done = 1'b1;
        result = din >> 1;
      end else begin
        done = 1'b0;
      end
      wait_n = in_wait ? wait_n + 1 : 0;
    end
  end

  // Monitor: compares delivered results and timeouts against the scoreboard.
  initial begin
    int pending;
    rd_idx = 0;
    n_to_seen = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rd_idx = sb_q.size();
      end else begin
        if (start) check_eq("start_while_out_valid", out_valid, 0);
        if ((out_valid && out_ready) || timeout_err) begin
          pending = sb_q.size() - rd_idx;
          check_eq("sb_pending", pending > 0, 1);
          if (pending > 0) begin
            if (timeout_err) begin
              n_to_seen++;
              check_eq("sb_timeout_expected", sb_q[rd_idx].to, 1);
            end else begin
              check_eq("sb_result_expected", sb_q[rd_idx].to, 0);
              check_eq("sb_data", out_data, sb_q[rd_idx].data);
            end
            rd_idx++;
          end
        end
      end
    end
  end

  task automatic push_job(input logic [DW-1:0] d, input logic to);
    exp_t e;
    int k;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      check_eq("push_ready", in_ready, 1);
    end else begin
      in_valid = 1'b1;
      in_data  = d;
      @(posedge clk);
      e.to = to;
      e.data = d >> 1;
      sb_q.push_back(e);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input string tag);
    int k;
    k = 0;
    while ((rd_idx != sb_q.size() || busy) && k < 400) begin
      @(negedge clk);
      k++;
    end
    check_eq(tag, (rd_idx == sb_q.size()) && !busy, 1);
  endtask

  task automatic spur_pulse();
    @(posedge clk);
    #1 spur_req = 1'b1;
    @(posedge clk);
    #1 spur_req = 1'b0;
  endtask

  initial begin
    int found;
    int to_before;
    int start_seen;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_start", start, 0);
    check_eq("rst_din", din, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_timeout_err", timeout_err, 0);
    rst = 1'b0;

    // Single job with exact start timing and held result.
    cu_delay = 2;
    push_job(8'h2A, 1'b0);
    @(negedge clk); check_eq("t1_start_e0", start, 0); check_eq("t1_busy_e0", busy, 0);
    @(negedge clk); check_eq("t1_start_e1", start, 1); check_eq("t1_din", din, 8'h2A);
    @(negedge clk); check_eq("t1_start_e2", start, 1);
    @(negedge clk); check_eq("t1_start_e3", start, 0); check_eq("t1_busy_wait", busy, 1);
    @(negedge clk); check_eq("t1_ovalid_e4", out_valid, 0);
    @(negedge clk); check_eq("t1_ovalid_e5", out_valid, 0);
    @(negedge clk); check_eq("t1_ovalid_e6", out_valid, 1); check_eq("t1_odata", out_data, 8'h15);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("t1_hold_valid", out_valid, 1);
      check_eq("t1_hold_data", out_data, 8'h15);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk); check_eq("t1_ovalid_clr", out_valid, 0); check_eq("t1_busy_clr", busy, 0);

    // Back-to-back jobs fill the buffer; the sixth stalls until a pop.
    out_ready = 1'b0;
    cu_delay = 1;
    for (int i = 1; i <= 5; i++) push_job(8'(i), 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); check_eq("t2_full_in_ready", in_ready, 0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    push_job(8'h06, 1'b0);
    wait_drain("t2_drain");

    // Timeout: first job never answered, second one completes.
    cu_delay = 8;
    push_job(8'h10, 1'b1);
    push_job(8'h11, 1'b0);
    found = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy && !start && !out_valid) begin
        found = 1;
        break;
      end
    end
    check_eq("t3_wait_entry", found, 1);
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      check_eq("t3_no_early_to", timeout_err, 0);
      check_eq("t3_no_ovalid", out_valid, 0);
    end
    @(negedge clk);
    check_eq("t3_to_pulse", timeout_err, 1);
    check_eq("t3_to_busy", busy, 0);
    check_eq("t3_to_ovalid", out_valid, 0);
    cu_delay = 1;
    @(negedge clk);
    check_eq("t3_to_single", timeout_err, 0);
    check_eq("t3_next_start", start, 1);
    check_eq("t3_next_din", din, 8'h11);
    wait_drain("t3_drain");

    // done in the final WAIT cycle wins over the timeout.
    cu_delay = 7;
    to_before = n_to_seen;
    push_job(8'h20, 1'b0);
    wait_drain("t4_drain");
    check_eq("t4_no_timeout", n_to_seen, to_before);
    check_eq("t4_odata", out_data, 8'h10);

    // Spurious done in IDLE, LOAD and HOLD.
    spur_pulse();
    @(negedge clk);
    check_eq("t5_idle_busy", busy, 0);
    check_eq("t5_idle_ovalid", out_valid, 0);
    check_eq("t5_idle_odata", out_data, 8'h10);
    out_ready = 1'b0;
    cu_delay = 3;
    push_job(8'h30, 1'b0);
    spur_pulse();
    @(negedge clk); check_eq("t5_load_start", start, 1); check_eq("t5_load_ovalid", out_valid, 0);
    @(negedge clk); check_eq("t5_wait_start", start, 0); check_eq("t5_wait_ovalid", out_valid, 0);
    found = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) begin
        found = 1;
        break;
      end
    end
    check_eq("t5_result_seen", found, 1);
    check_eq("t5_odata", out_data, 8'h18);
    spur_pulse();
    @(negedge clk);
    check_eq("t5_hold_odata", out_data, 8'h18);
    check_eq("t5_hold_ovalid", out_valid, 1);
    @(posedge clk); #1 out_ready = 1'b1;
    wait_drain("t5_drain");

    // Reset in the middle of LOAD with three jobs buffered.
    out_ready = 1'b0;
    cu_delay = 1;
    push_job(8'h40, 1'b0);
    found = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) begin
        found = 1;
        break;
      end
    end
    check_eq("t6_first_hold", found, 1);
    for (int i = 1; i <= 4; i++) push_job(8'(8'h40 + i), 1'b0);
    @(negedge clk); check_eq("t6_full", in_ready, 0);
    @(posedge clk); #1 out_ready = 1'b1;
    found = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (start) begin
        found = 1;
        break;
      end
    end
    check_eq("t6_load_seen", found, 1);
    #2 rst = 1'b1;
    #1;
    check_eq("t6_rst_start", start, 0);
    check_eq("t6_rst_busy", busy, 0);
    check_eq("t6_rst_ovalid", out_valid, 0);
    check_eq("t6_rst_in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    start_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (start || busy) start_seen = 1;
    end
    check_eq("t6_no_relaunch", start_seen, 0);
    push_job(8'h50, 1'b0);
    wait_drain("t6_drain");
    check_eq("t6_odata", out_data, 8'h28);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
